block_normalizer: RTL and testbench



---
 rtl/block_normalizer.sv | 147 ++++++++++++++
 tb/tb_block_normalizer.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/block_normalizer.sv
// block_normalizer: block-floating-point normalizer.
// Collects DEPTH signed samples, finds the largest left shift that keeps every
// sample in range (capped at the exponent range), then streams the block back
// out shifted by that amount together with the shift as the block exponent.
module block_normalizer #(
  parameter int WIDTH      = 8,
  parameter int SHIFT_BITS = 3,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic [SHIFT_BITS-1:0] out_exp,
  output logic                  out_last
);

  localparam int IDXW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int RSBW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam int MAX_SH = (1 << SHIFT_BITS) - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);
  localparam logic [RSBW-1:0] MAX_RSB  = RSBW'(WIDTH - 1);

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t                r_state;
  logic [IDXW-1:0]       r_idx;
  logic [RSBW-1:0]       r_minRsb;
  logic [WIDTH-1:0]      r_buf [DEPTH];
  logic                  r_inReady;
  logic                  r_outValid;
  logic [WIDTH-1:0]      r_outData;
  logic [SHIFT_BITS-1:0] r_outExp;
  logic                  r_outLast;

  logic                  w_accept;
  logic                  w_outFire;
  logic [RSBW-1:0]       w_sampleRsb;
  logic [RSBW-1:0]       w_blockMin;
  logic [SHIFT_BITS-1:0] w_blockSh;
  logic [IDXW-1:0]       w_nextIdx;

  // Redundant sign bits: leading bits equal to the sign bit, minus one.
  function automatic logic [RSBW-1:0] rsbOf(input logic [WIDTH-1:0] x);
    logic [RSBW-1:0] n;
    logic            run;
    n   = '0;
    run = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--) begin
      if (run && (x[i] == x[WIDTH-1])) begin
        n = n + 1'b1;
      end else begin
        run = 1'b0;
      end
    end
    return n;
  endfunction

  assign w_accept  = in_valid && r_inReady && (r_state == FILL);
  assign w_outFire = r_outValid && out_ready;
  assign w_nextIdx = r_idx + 1'b1;

  // Block minimum including the sample being accepted, and the capped shift.
  always_comb begin
    w_sampleRsb = rsbOf(in_data);
    w_blockMin  = (w_sampleRsb < r_minRsb) ? w_sampleRsb : r_minRsb;
    w_blockSh   = '0;
    if (int'(w_blockMin) > MAX_SH) begin
      w_blockSh = SHIFT_BITS'(MAX_SH);
    end else begin
      w_blockSh = SHIFT_BITS'(w_blockMin);
    end
  end

  // Sample storage; contents need no reset because every block rewrites them.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_buf[r_idx] <= in_data;
    end
  end

  // Fill/drain controller with registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= FILL;
      r_idx      <= '0;
      r_minRsb   <= MAX_RSB;
      r_inReady  <= 1'b1;
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outExp   <= '0;
      r_outLast  <= 1'b0;
    end else begin
      case (r_state)
        FILL: begin
          if (w_accept) begin
            if (r_idx == LAST_IDX) begin
              r_state    <= DRAIN;
              r_idx      <= '0;
              r_inReady  <= 1'b0;
              r_outValid <= 1'b1;
              r_outData  <= r_buf[0] << w_blockSh;
              r_outExp   <= w_blockSh;
              r_outLast  <= 1'b0;
            end else begin
              r_idx    <= w_nextIdx;
              r_minRsb <= w_blockMin;
            end
          end
        end
        DRAIN: begin
          if (w_outFire) begin
            if (r_outLast) begin
              r_state    <= FILL;
              r_idx      <= '0;
              r_minRsb   <= MAX_RSB;
              r_inReady  <= 1'b1;
              r_outValid <= 1'b0;
              r_outLast  <= 1'b0;
            end else begin
              r_idx     <= w_nextIdx;
              r_outData <= r_buf[w_nextIdx] << r_outExp;
              r_outLast <= (w_nextIdx == LAST_IDX);
            end
          end
        end
        default: begin
          r_state <= FILL;
        end
      endcase
    end
  end

  assign in_ready  = r_inReady;
  assign out_valid = r_outValid;
  assign out_data  = r_outData;
  assign out_exp   = r_outExp;
  assign out_last  = r_outLast;

endmodule

// File: tb/tb_block_normalizer.sv
// Testbench for block_normalizer: an 8-bit and a 16-bit instance driven with
// directed and random blocks, checked against an arithmetic reference model.
module tb_block_normalizer;

  logic        clk;
  logic        rst;

  logic        inValidA, inReadyA, outValidA, outReadyA, outLastA;
  logic [7:0]  inDataA, outDataA;
  logic [2:0]  outExpA;

  logic        inValidB, inReadyB, outValidB, outReadyB, outLastB;
  logic [15:0] inDataB, outDataB;
  logic [2:0]  outExpB;

  int vecCount;
  int errCount;
  int blk [4];

  logic [15:0]        rawVal;
  logic signed [7:0]  t8;
  logic signed [15:0] t16;

  block_normalizer #(.WIDTH(8), .SHIFT_BITS(3), .DEPTH(4)) dutA (
    .clk(clk), .rst(rst),
    .in_valid(inValidA), .in_ready(inReadyA), .in_data(inDataA),
    .out_valid(outValidA), .out_ready(outReadyA), .out_data(outDataA),
    .out_exp(outExpA), .out_last(outLastA)
  );

  block_normalizer #(.WIDTH(16), .SHIFT_BITS(3), .DEPTH(4)) dutB (
    .clk(clk), .rst(rst),
    .in_valid(inValidB), .in_ready(inReadyB), .in_data(inDataB),
    .out_valid(outValidB), .out_ready(outReadyB), .out_data(outDataB),
    .out_exp(outExpB), .out_last(outLastB)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a wait never resolves.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Largest k such that x * 2^k still fits a w-bit signed value, capped at w-1.
  function automatic int rsbModel(input int x, input int w);
    int k, v, lo, hi;
    lo = -(1 << (w - 1));
    hi = (1 << (w - 1)) - 1;
    k  = 0;
    while (k < w - 1) begin
      v = x * (1 << (k + 1));
      if (v < lo || v > hi) break;
      k++;
    end
    return k;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecCount++;
    assert (obs === expv) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic setIn(input int sel, input logic v, input logic [15:0] d);
    if (sel == 0) begin
      inValidA = v;
      inDataA  = d[7:0];
    end else begin
      inValidB = v;
      inDataB  = d;
    end
  endtask

  task automatic setReady(input int sel, input logic r);
    if (sel == 0) outReadyA = r;
    else          outReadyB = r;
  endtask

  task automatic sampleOut(input int sel, output logic v, output logic ir,
                           output logic [15:0] d, output logic [2:0] e, output logic l);
    if (sel == 0) begin
      v = outValidA; ir = inReadyA; d = {8'h00, outDataA}; e = outExpA; l = outLastA;
    end else begin
      v = outValidB; ir = inReadyB; d = outDataB; e = outExpB; l = outLastB;
    end
  endtask

  task automatic pulseReset();
    setIn(0, 1'b0, 16'h0);
    setIn(1, 1'b0, 16'h0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic checkIdleAfterReset(input int sel, input string tag);
    logic v, ir, l;
    logic [15:0] d;
    logic [2:0] e;
    sampleOut(sel, v, ir, d, e, l);
    checkOutput({tag, "_out_valid"}, 32'(v), 32'd0);
    checkOutput({tag, "_in_ready"}, 32'(ir), 32'd1);
  endtask

  // Random block: a random value arithmetic-shifted right by a random amount
  // so that the block exponents cover the full range.
  task automatic genBlock(input int sel);
    int w, r;
    w = (sel == 0) ? 8 : 16;
    for (int k = 0; k < 4; k++) begin
      rawVal = 16'($urandom);
      r = int'($urandom_range(0, w - 1));
      if (sel == 0) begin
        t8 = rawVal[7:0];
        blk[k] = int'(t8) >>> r;
      end else begin
        t16 = rawVal;
        blk[k] = int'(t16) >>> r;
      end
    end
  endtask

  // Push one block in, drain it with the chosen out_ready mode, check all.
  // mode 0: out_ready held 1; mode 1: 1,0,0,1,0,1,1; mode 2: random.
  task automatic applyStimulus(input int sel, input int mode);
    int w, sh, minR, j, cyc, tmp;
    int pat [7];
    logic r, v, ir, l;
    logic [15:0] mask, d;
    logic [15:0] expD [4];
    logic [2:0] e;
    pat = '{1, 0, 0, 1, 0, 1, 1};
    w    = (sel == 0) ? 8 : 16;
    mask = (sel == 0) ? 16'h00FF : 16'hFFFF;
    minR = w - 1;
    for (int k = 0; k < 4; k++) begin
      if (rsbModel(blk[k], w) < minR) minR = rsbModel(blk[k], w);
    end
    sh = (minR > 7) ? 7 : minR;
    for (int k = 0; k < 4; k++) begin
      tmp = blk[k] * (1 << sh);
      expD[k] = 16'(tmp) & mask;
    end

    sampleOut(sel, v, ir, d, e, l);
    checkOutput("fill_start_in_ready", 32'(ir), 32'd1);
    checkOutput("fill_start_out_valid", 32'(v), 32'd0);
    for (int k = 0; k < 4; k++) begin
      setIn(sel, 1'b1, 16'(blk[k]));
      setReady(sel, 1'($urandom));
      @(posedge clk);
      @(negedge clk);
      sampleOut(sel, v, ir, d, e, l);
      if (k < 3) begin
        checkOutput("fill_out_valid", 32'(v), 32'd0);
        checkOutput("fill_in_ready", 32'(ir), 32'd1);
      end
    end

    j   = 0;
    cyc = 0;
    while (j < 4 && cyc < 64) begin
      case (mode)
        1:       r = (cyc < 7) ? 1'(pat[cyc]) : 1'b1;
        2:       r = (cyc > 20) ? 1'b1 : 1'($urandom);
        default: r = 1'b1;
      endcase
      setReady(sel, r);
      setIn(sel, 1'b1, 16'($urandom));
      sampleOut(sel, v, ir, d, e, l);
      checkOutput("drain_out_valid", 32'(v), 32'd1);
      checkOutput("drain_in_ready", 32'(ir), 32'd0);
      checkOutput("drain_data", 32'(d), 32'(expD[j]));
      checkOutput("drain_exp", 32'(e), 32'(sh));
      checkOutput("drain_last", 32'(l), 32'(j == 3));
      @(posedge clk);
      if (r) j++;
      cyc++;
      @(negedge clk);
    end
    if (j < 4) begin
      vecCount++;
      errCount++;
      $display("[TB] FAIL drain_timeout observed=%0d expected=4", j);
    end
    setIn(sel, 1'b0, 16'h0);
    sampleOut(sel, v, ir, d, e, l);
    checkOutput("post_in_ready", 32'(ir), 32'd1);
    checkOutput("post_out_valid", 32'(v), 32'd0);
  endtask

  initial begin
    logic v, ir, l;
    logic [15:0] d;
    logic [2:0] e;
    vecCount = 0;
    errCount = 0;
    rst = 1'b1;
    inValidA = 1'b0; inDataA = '0; outReadyA = 1'b0;
    inValidB = 1'b0; inDataB = '0; outReadyB = 1'b0;
    repeat (2) @(negedge clk);

    for (int s = 0; s < 2; s++) begin
      sampleOut(s, v, ir, d, e, l);
      checkOutput("reset_in_ready", 32'(ir), 32'd1);
      checkOutput("reset_out_valid", 32'(v), 32'd0);
      checkOutput("reset_out_data", 32'(d), 32'd0);
      checkOutput("reset_out_exp", 32'(e), 32'd0);
      checkOutput("reset_out_last", 32'(l), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] basic block");
    blk = '{3, -4, 1, 0};
    applyStimulus(0, 0);

    $display("[TB] full-scale block");
    blk = '{127, 16, -128, 0};
    applyStimulus(0, 0);

    $display("[TB] degenerate blocks");
    blk = '{0, 0, 0, 0};
    applyStimulus(0, 0);
    blk = '{-1, -1, -1, -1};
    applyStimulus(0, 0);

    $display("[TB] backpressure");
    blk = '{3, -4, 1, 0};
    applyStimulus(0, 1);

    $display("[TB] saturation");
    blk = '{1, 2, 0, -1};
    applyStimulus(1, 0);

    $display("[TB] reset during fill");
    setIn(0, 1'b1, 16'h007F);
    @(posedge clk); @(negedge clk);
    setIn(0, 1'b1, 16'h0080);
    @(posedge clk); @(negedge clk);
    pulseReset();
    checkIdleAfterReset(0, "rst_fill");
    blk = '{1, 2, -2, 3};
    applyStimulus(0, 0);

    $display("[TB] reset during drain");
    setReady(0, 1'b1);
    blk = '{64, -100, 5, 7};
    for (int k = 0; k < 4; k++) begin
      setIn(0, 1'b1, 16'(blk[k]));
      @(posedge clk); @(negedge clk);
    end
    setIn(0, 1'b0, 16'h0);
    @(posedge clk); @(negedge clk);
    pulseReset();
    checkIdleAfterReset(0, "rst_drain");
    blk = '{0, 1, -1, 2};
    applyStimulus(0, 0);

    $display("[TB] random blocks");
    for (int b = 0; b < 24; b++) begin
      genBlock(b % 2);
      applyStimulus(b % 2, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
